guardian_alert_collector: RTL and testbench

Receive-side endpoint for guardian alert outputs. Samples the per-block `alert_valid` / `anomaly_score` / `block_id` triples from up to `NUM_BLOCKS` guardians and turns each new alert into one event. Events are latched per source, arbitrated round-robin into a FIFO, and presented to the healing controller over a valid/ready handshake. Sits between the guardian array and the self-healing controller.

---
 rtl/guardian_alert_collector.sv | 189 ++++++++++++++++++
 tb/tb_guardian_alert_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/guardian_alert_collector.sv
// Guardian alert collector: edge-detects per-source alerts, latches or coalesces them, and
// round-robins them into an FWFT event FIFO. Define GUARDIAN_COALESCE_MAX_EN to keep the max score on coalesce.

module guardian_alert_lane #(
   parameter int SCORE_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   new_alert,
   input  logic                   grant,
   input  logic [SCORE_WIDTH-1:0] score_in,
   input  logic [15:0]            id_in,
   output logic                   pending,
   output logic                   merged,
   output logic                   coalesce_inc,
   output logic [SCORE_WIDTH-1:0] score,
   output logic [15:0]            id
);
   logic                   pending_q, pending_d, merged_q, merged_d;
   logic [SCORE_WIDTH-1:0] score_q, score_d;
   logic [15:0]            id_q, id_d;

   // A grant drains the old latch, so a same-cycle alert starts a fresh, unmerged entry.
   always_comb begin
      pending_d    = pending_q;
      merged_d     = merged_q;
      score_d      = score_q;
      id_d         = id_q;
      coalesce_inc = 1'b0;
      if (new_alert && (grant || !pending_q)) begin
         pending_d = 1'b1;
         merged_d  = 1'b0;
         score_d   = score_in;
         id_d      = id_in;
      end else if (new_alert) begin
         merged_d     = 1'b1;
         coalesce_inc = 1'b1;
         id_d         = id_in;
`ifdef GUARDIAN_COALESCE_MAX_EN
         if (score_in > score_q) score_d = score_in;
`endif
      end else if (grant) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 1'b0;
         merged_q  <= 1'b0;
         score_q   <= '0;
         id_q      <= '0;
      end else begin
         pending_q <= pending_d;
         merged_q  <= merged_d;
         score_q   <= score_d;
         id_q      <= id_d;
      end
   end

   assign pending = pending_q;
   assign merged  = merged_q;
   assign score   = score_q;
   assign id      = id_q;
endmodule

module guardian_alert_collector #(
   parameter int NUM_BLOCKS  = 4,
   parameter int SCORE_WIDTH = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_BLOCKS-1:0]             in_alert_valid,
   input  logic [NUM_BLOCKS*SCORE_WIDTH-1:0] in_score,
   input  logic [NUM_BLOCKS*16-1:0]          in_block_id,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [15:0]                       out_block_id,
   output logic [SCORE_WIDTH-1:0]            out_score,
   output logic                              out_coalesced,
   output logic [NUM_BLOCKS-1:0]             pending_mask,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
   output logic [15:0]                       coalesce_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int GW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam int EW = 16 + SCORE_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [NUM_BLOCKS-1:0]                  valid_q, valid_d, new_alert;
   logic [NUM_BLOCKS-1:0]                  lane_pending, lane_merged, lane_inc;
   logic [NUM_BLOCKS-1:0][SCORE_WIDTH-1:0] lane_score;
   logic [NUM_BLOCKS-1:0][15:0]            lane_id;
   logic [GW-1:0]                          last_grant_q, last_grant_d, gnt_idx, cand;
   logic                                   gnt_vld, push, pop;
   logic [FIFO_DEPTH-1:0][EW-1:0]          mem_q, mem_d;
   logic [PW-1:0]                          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                          count_q, count_d;
   logic [15:0]                            cc_q, cc_d;
   logic [4:0]                             inc_cnt;
   logic [16:0]                            cc_sum;
   logic [EW-1:0]                          head;
   int                                     idx;

   assign valid_d   = in_alert_valid;
   assign new_alert = in_alert_valid & ~valid_q;

   for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_lane
      guardian_alert_lane #(.SCORE_WIDTH(SCORE_WIDTH)) u_lane (
         .clk          (clk),
         .rst          (rst),
         .new_alert    (new_alert[i]),
         .grant        (gnt_vld && (gnt_idx == GW'(i))),
         .score_in     (in_score[i*SCORE_WIDTH +: SCORE_WIDTH]),
         .id_in        (in_block_id[i*16 +: 16]),
         .pending      (lane_pending[i]),
         .merged       (lane_merged[i]),
         .coalesce_inc (lane_inc[i]),
         .score        (lane_score[i]),
         .id           (lane_id[i])
      );
   end

   // Round-robin search starting just past the last grant; room is judged on registered occupancy.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      idx     = 0;
      for (int k = 1; k <= NUM_BLOCKS; k++) begin
         idx = int'(last_grant_q) + k;
         if (idx >= NUM_BLOCKS) idx = idx - NUM_BLOCKS;
         cand = GW'(idx);
         if (!gnt_vld && lane_pending[cand] && (count_q < DEPTH_C)) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      last_grant_d = gnt_vld ? gnt_idx : last_grant_q;
   end

   always_comb begin
      push     = gnt_vld;
      pop      = (count_q != '0) && out_ready;
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = {lane_id[gnt_idx], lane_score[gnt_idx], lane_merged[gnt_idx]};
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      inc_cnt = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) inc_cnt = inc_cnt + {4'b0, lane_inc[i]};
      cc_sum = {1'b0, cc_q} + {12'b0, inc_cnt};
      cc_d   = cc_sum[16] ? 16'hFFFF : cc_sum[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         last_grant_q <= GW'(NUM_BLOCKS - 1);
         mem_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         cc_q         <= '0;
      end else begin
         valid_q      <= valid_d;
         last_grant_q <= last_grant_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         cc_q         <= cc_d;
      end
   end

   assign head           = mem_q[rd_ptr_q];
   assign out_valid      = (count_q != '0);
   assign out_block_id   = head[EW-1 -: 16];
   assign out_score      = head[SCORE_WIDTH:1];
   assign out_coalesced  = head[0];
   assign pending_mask   = lane_pending;
   assign fifo_count     = count_q;
   assign coalesce_count = cc_q;
endmodule

// File: tb/tb_guardian_alert_collector.sv
// Bench for guardian_alert_collector: directed scenarios plus randomized traffic against a queue-based model.
module tb_guardian_alert_collector;
   localparam int NB = 4, SW = 16, DEPTH = 8, CW = $clog2(DEPTH) + 1;
`ifdef GUARDIAN_COALESCE_MAX_EN
   localparam logic [15:0] EXP9 = 16'd200;
`else
   localparam logic [15:0] EXP9 = 16'd50;
`endif

   logic             clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
   logic [NB-1:0]    in_alert_valid = '0;
   logic [NB*SW-1:0] in_score = '0;
   logic [NB*16-1:0] in_block_id = '0;
   logic             out_valid, out_coalesced;
   logic [15:0]      out_block_id, coalesce_count;
   logic [SW-1:0]    out_score;
   logic [NB-1:0]    pending_mask;
   logic [CW-1:0]    fifo_count;
   int               n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   guardian_alert_collector #(.NUM_BLOCKS(NB), .SCORE_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_alert_valid(in_alert_valid), .in_score(in_score),
      .in_block_id(in_block_id), .out_valid(out_valid), .out_ready(out_ready),
      .out_block_id(out_block_id), .out_score(out_score), .out_coalesced(out_coalesced),
      .pending_mask(pending_mask), .fifo_count(fifo_count), .coalesce_count(coalesce_count));

   // Reference model: per-source latches as arrays, event FIFO as a queue.
   typedef struct { logic [15:0] id; logic [15:0] score; bit merged; } ev_t;
   ev_t         mq[$];
   bit          m_pend[NB], m_mrg[NB], m_prev[NB];
   logic [15:0] m_sc[NB], m_id[NB];
   int          m_last, m_cc;

   always @(posedge clk) begin : model
      int g; ev_t e; ev_t d; bit nw;
      if (rst) begin
         mq.delete(); m_last = NB - 1; m_cc = 0;
         for (int i = 0; i < NB; i++) begin m_pend[i] = 0; m_mrg[i] = 0; m_prev[i] = 0; m_sc[i] = 0; m_id[i] = 0; end
      end else begin
         g = -1;
         if (mq.size() < DEPTH)
            for (int k = 1; k <= NB; k++) if (g < 0 && m_pend[(m_last + k) % NB]) g = (m_last + k) % NB;
         if (mq.size() > 0 && out_ready) d = mq.pop_front();
         if (g >= 0) begin
            e.id = m_id[g]; e.score = m_sc[g]; e.merged = m_mrg[g];
            mq.push_back(e); m_last = g; m_pend[g] = 0;
         end
         for (int i = 0; i < NB; i++) begin
            nw = in_alert_valid[i] && !m_prev[i];
            if (nw && !m_pend[i]) begin
               m_pend[i] = 1; m_mrg[i] = 0; m_sc[i] = in_score[i*SW +: SW]; m_id[i] = in_block_id[i*16 +: 16];
            end else if (nw) begin
               m_mrg[i] = 1; m_id[i] = in_block_id[i*16 +: 16];
`ifdef GUARDIAN_COALESCE_MAX_EN
               if (in_score[i*SW +: SW] > m_sc[i]) m_sc[i] = in_score[i*SW +: SW];
`endif
               if (m_cc < 65535) m_cc++;
            end
            m_prev[i] = in_alert_valid[i];
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask

   task automatic drive(int i, bit v, logic [15:0] sc, logic [15:0] id);
      in_alert_valid[i] = v; in_score[i*SW +: SW] = sc; in_block_id[i*16 +: 16] = id;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_alert_valid = '0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_alert_valid = NB'($urandom); out_ready = 1'b1;
      tick(); in_alert_valid = '0; tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0h want 0", out_valid); end
      n_cmp++; if (out_block_id !== 16'h0) begin n_err++; $display("FAIL rst_id got %0h want 0", out_block_id); end
      n_cmp++; if (out_score !== '0) begin n_err++; $display("FAIL rst_score got %0h want 0", out_score); end
      n_cmp++; if (out_coalesced !== 1'b0) begin n_err++; $display("FAIL rst_coal got %0h want 0", out_coalesced); end
      n_cmp++; if (pending_mask !== '0) begin n_err++; $display("FAIL rst_pend got %0h want 0", pending_mask); end
      n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL rst_count got %0h want 0", fifo_count); end
      n_cmp++; if (coalesce_count !== 16'h0) begin n_err++; $display("FAIL rst_cc got %0h want 0", coalesce_count); end
      rst = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_single();
      do_reset(); out_ready = 1'b1;
      repeat (10) tick();
      drive(2, 1, 16'd100, 16'd2); tick();
      n_cmp++; if (out_valid !== 1'b0 || pending_mask !== 4'b0100) begin
         n_err++; $display("FAIL single_t1 got valid=%0h pend=%0h want 0/4", out_valid, pending_mask); end
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0h want 1", out_valid); end
      n_cmp++; if (out_score !== 16'd100) begin n_err++; $display("FAIL single_score got %0d want 100", out_score); end
      n_cmp++; if (out_block_id !== 16'd2) begin n_err++; $display("FAIL single_id got %0d want 2", out_block_id); end
      n_cmp++; if (out_coalesced !== 1'b0) begin n_err++; $display("FAIL single_coal got %0h want 0", out_coalesced); end
      drive(2, 0, 16'd100, 16'd2); tick();
      n_cmp++; if (fifo_count !== '0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL single_drain got count=%0d valid=%0h want 0/0", fifo_count, out_valid); end
   endtask

   task automatic test_held();
      int cnt = 0;
      do_reset(); out_ready = 1'b1;
      drive(0, 1, 16'd90, 16'd0);
      repeat (50) begin tick(); if (out_valid) cnt++; end
      drive(0, 0, 16'd90, 16'd0);
      repeat (5) begin tick(); if (out_valid) cnt++; end
      n_cmp++; if (cnt != 1) begin n_err++; $display("FAIL held_events got %0d want 1", cnt); end
      n_cmp++; if (coalesce_count !== 16'h0) begin n_err++; $display("FAIL held_cc got %0d want 0", coalesce_count); end
   endtask

   task automatic test_round_robin();
      do_reset(); out_ready = 1'b1;
      for (int i = 0; i < NB; i++) drive(i, 1, 16'(10 + i), 16'(i));
      tick(); tick();
      for (int i = 0; i < NB; i++) begin
         n_cmp++; if (out_valid !== 1'b1 || out_block_id !== 16'(i)) begin
            n_err++; $display("FAIL rr_order[%0d] got valid=%0h id=%0d want 1/%0d", i, out_valid, out_block_id, i); end
         tick();
      end
      in_alert_valid = '0;
      repeat (4) tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_drained got %0h want 0", out_valid); end
      drive(3, 1, 16'd33, 16'd3); drive(0, 1, 16'd30, 16'd0);
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b1 || out_block_id !== 16'd0) begin
         n_err++; $display("FAIL rr_wrap_first got valid=%0h id=%0d want 1/0", out_valid, out_block_id); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_block_id !== 16'd3) begin
         n_err++; $display("FAIL rr_wrap_second got valid=%0h id=%0d want 1/3", out_valid, out_block_id); end
      in_alert_valid = '0;
   endtask

   task automatic test_backpressure();
      do_reset(); out_ready = 1'b0;
      for (int e = 0; e < 8; e++) begin
         drive(e % NB, 1, 16'(e * 3), 16'(e)); tick();
         in_alert_valid[e % NB] = 1'b0; tick();
      end
      repeat (2) tick();
      n_cmp++; if (fifo_count !== CW'(8)) begin n_err++; $display("FAIL bp_full got %0d want 8", fifo_count); end
      drive(1, 1, 16'd50, 16'h21); tick(); in_alert_valid[1] = 1'b0; tick();
      drive(1, 1, 16'd200, 16'h22); tick(); in_alert_valid[1] = 1'b0; tick();
      n_cmp++; if (fifo_count !== CW'(8)) begin n_err++; $display("FAIL bp_still_full got %0d want 8", fifo_count); end
      n_cmp++; if (pending_mask[1] !== 1'b1) begin n_err++; $display("FAIL bp_pend1 got %0h want 1", pending_mask[1]); end
      n_cmp++; if (coalesce_count !== 16'd1) begin n_err++; $display("FAIL bp_cc got %0d want 1", coalesce_count); end
      out_ready = 1'b1;
      for (int e = 0; e < 8; e++) begin
         n_cmp++; if (out_valid !== 1'b1 || out_block_id !== 16'(e)) begin
            n_err++; $display("FAIL bp_drain[%0d] got valid=%0h id=%0d want 1/%0d", e, out_valid, out_block_id, e); end
         tick();
      end
      n_cmp++; if (out_valid !== 1'b1 || out_block_id !== 16'h22 || out_coalesced !== 1'b1) begin
         n_err++; $display("FAIL bp_ninth got valid=%0h id=%0h coal=%0h want 1/22/1", out_valid, out_block_id, out_coalesced); end
      n_cmp++; if (out_score !== EXP9) begin n_err++; $display("FAIL bp_ninth_score got %0d want %0d", out_score, EXP9); end
      n_cmp++; if (coalesce_count !== 16'd1) begin n_err++; $display("FAIL bp_cc_end got %0d want 1", coalesce_count); end
   endtask

   task automatic test_collision();
      logic [15:0] ids[$], scs[$]; bit cos[$];
      logic [15:0] exp_id[3] = '{16'd0, 16'd1, 16'd1};
      logic [15:0] exp_sc[3] = '{16'd5, 16'd60, 16'd77};
      do_reset(); out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         case (c)
            0: begin drive(0, 1, 16'd5, 16'd0); drive(1, 1, 16'd60, 16'd1); end
            1: in_alert_valid[1] = 1'b0;
            2: drive(1, 1, 16'd77, 16'd1);
            3: in_alert_valid = '0;
            default: ;
         endcase
         tick();
         if (out_valid) begin ids.push_back(out_block_id); scs.push_back(out_score); cos.push_back(out_coalesced); end
      end
      n_cmp++; if (ids.size() != 3) begin n_err++; $display("FAIL coll_events got %0d want 3", ids.size()); end
      for (int k = 0; k < 3; k++) if (k < ids.size()) begin
         n_cmp++; if (ids[k] !== exp_id[k] || scs[k] !== exp_sc[k] || cos[k] !== 1'b0) begin
            n_err++; $display("FAIL coll_ev[%0d] got id=%0d score=%0d coal=%0h want %0d/%0d/0",
                              k, ids[k], scs[k], cos[k], exp_id[k], exp_sc[k]); end
      end
      n_cmp++; if (coalesce_count !== 16'd0) begin n_err++; $display("FAIL coll_cc got %0d want 0", coalesce_count); end
   endtask

   task automatic test_reset_mid();
      do_reset(); out_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive(i, 1, 16'(i + 1), 16'(i));
      repeat (4) tick();
      in_alert_valid = '0; tick();
      drive(1, 1, 16'd11, 16'd1); drive(2, 1, 16'd12, 16'd2); tick();
      n_cmp++; if (fifo_count !== CW'(3) || pending_mask !== 4'b0110) begin
         n_err++; $display("FAIL rmid_pre got count=%0d pend=%0h want 3/6", fifo_count, pending_mask); end
      rst = 1'b1; drive(0, 1, 16'd33, 16'd0); tick();
      n_cmp++; if ({out_valid, out_block_id, out_score, out_coalesced, pending_mask, fifo_count, coalesce_count} !== '0) begin
         n_err++; $display("FAIL rmid_zero got valid=%0h id=%0h score=%0h coal=%0h pend=%0h count=%0d cc=%0d want all 0",
                           out_valid, out_block_id, out_score, out_coalesced, pending_mask, fifo_count, coalesce_count); end
      rst = 1'b0; tick(); tick();
      n_cmp++; if (out_valid !== 1'b1 || out_block_id !== 16'd0 || out_score !== 16'd33 || fifo_count !== CW'(1)) begin
         n_err++; $display("FAIL rmid_after got valid=%0h id=%0d score=%0d count=%0d want 1/0/33/1",
                           out_valid, out_block_id, out_score, fifo_count); end
      in_alert_valid = '0;
   endtask

   task automatic test_random();
      logic [NB-1:0] exp_pm;
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int i = 0; i < NB; i++) if ($urandom_range(0, 3) == 0)
            drive(i, ~in_alert_valid[i], 16'($urandom), 16'($urandom));
         out_ready = ((cyc / 60) % 3 == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
         tick();
         exp_pm = '0;
         for (int i = 0; i < NB; i++) exp_pm[i] = m_pend[i];
         n_cmp++; if (out_valid !== (mq.size() != 0)) begin
            n_err++; $display("FAIL rnd_valid@%0d got %0h want %0h", cyc, out_valid, mq.size() != 0); end
         if (mq.size() != 0) begin
            n_cmp++; if (out_block_id !== mq[0].id || out_score !== mq[0].score || out_coalesced !== mq[0].merged) begin
               n_err++; $display("FAIL rnd_head@%0d got %0h/%0h/%0h want %0h/%0h/%0h", cyc, out_block_id, out_score,
                                 out_coalesced, mq[0].id, mq[0].score, mq[0].merged); end
         end
         n_cmp++; if (pending_mask !== exp_pm) begin
            n_err++; $display("FAIL rnd_pend@%0d got %0h want %0h", cyc, pending_mask, exp_pm); end
         n_cmp++; if (fifo_count !== CW'(mq.size())) begin
            n_err++; $display("FAIL rnd_count@%0d got %0d want %0d", cyc, fifo_count, mq.size()); end
         n_cmp++; if (coalesce_count !== 16'(m_cc)) begin
            n_err++; $display("FAIL rnd_cc@%0d got %0d want %0d", cyc, coalesce_count, m_cc); end
      end
      in_alert_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_held();
      test_round_robin();
      test_backpressure();
      test_collision();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
